// File: rtl/data_mem_stage_pkg.sv
// Shared types and default widths for the data-memory stage.
package data_mem_stage_pkg;

   typedef enum logic {IDLE = 1'b0, WAIT = 1'b1} state_t;

   localparam logic [1:0] ST_REG = 2'd0;
   localparam logic [1:0] ST_EXE = 2'd1;
   localparam logic [1:0] ST_WB  = 2'd2;

   localparam int DATA_W_DEF = 16;
   localparam int ADDR_W_DEF = 6;
   localparam int REG_AW_DEF = 4;
   localparam int RD_LAT_DEF = 1;
   // wide enough for the maximum read latency of 15
   localparam int CNT_W      = 4;

endpackage

// File: rtl/data_mem_stage_if.sv
// Execute-side request and writeback-side response bundle of the data-memory stage.
interface data_mem_stage_if
   import data_mem_stage_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int REG_AW = REG_AW_DEF
) ();

   logic              do_halt;
   logic              do_branch;
   logic              is_mem_read;
   logic              is_mem_write;
   logic              is_reg_write;
   logic [DATA_W-1:0] base;
   logic [DATA_W-1:0] offset;
   logic [DATA_W-1:0] st_reg_val;
   logic [DATA_W-1:0] st_exe_val;
   logic [1:0]        st_sel;
   logic [REG_AW-1:0] dst_reg;
   logic              stall;
   logic              wb_valid;
   logic [DATA_W-1:0] wb_data;
   logic [REG_AW-1:0] wb_reg_addr;
   logic              fault;

   modport master (
      output do_halt, do_branch, is_mem_read, is_mem_write, is_reg_write,
             base, offset, st_reg_val, st_exe_val, st_sel, dst_reg,
      input  stall, wb_valid, wb_data, wb_reg_addr, fault
   );

   modport slave (
      input  do_halt, do_branch, is_mem_read, is_mem_write, is_reg_write,
             base, offset, st_reg_val, st_exe_val, st_sel, dst_reg,
      output stall, wb_valid, wb_data, wb_reg_addr, fault
   );

endinterface

// File: rtl/data_mem_stage_dmem_ram.sv
// Single-port synchronous RAM: registered read-before-write, synchronous whole-array clear.
module dmem_ram #(
   parameter int DATA_W = 16,
   parameter int ADDR_W = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              re,
   input  logic              we,
   input  logic [ADDR_W-1:0] idx,
   input  logic [DATA_W-1:0] wdata,
   output logic [DATA_W-1:0] rdata
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [DATA_W-1:0] mem [DEPTH];

   // rdata only moves on re, so it doubles as the load holding register
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         rdata <= '0;
      end else begin
         if (re) rdata <= mem[idx];
         if (we) mem[idx] <= wdata;
      end
   end

endmodule

// File: rtl/data_mem_stage.sv
// Data-memory stage: load/store FSM with configurable read latency and store forwarding.
// Optional macro MEM_BOUNDS_CHECK_EN suppresses out-of-range accesses and pulses fault.
module data_mem_stage
   import data_mem_stage_pkg::*;
#(
   parameter int DATA_W = DATA_W_DEF,
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int REG_AW = REG_AW_DEF,
   parameter int RD_LAT = RD_LAT_DEF
) (
   input  logic            clk,
   input  logic            rst,
   data_mem_stage_if.slave bus
);

   localparam int                 DEPTH   = 2 ** ADDR_W;
   localparam logic [CNT_W-1:0]   LAT_CNT = CNT_W'(RD_LAT - 1);
   localparam logic [CNT_W-1:0]   ONE     = CNT_W'(1);

   state_t            state, state_nx;
   logic [CNT_W-1:0]  cnt, cnt_nx;
   logic              wb_vld, wb_vld_nx;
   logic              fault_q, fault_nx;
   logic              hold_we;
   logic [REG_AW-1:0] hold_reg;
   logic              rd_go, wr_go;
   logic              oob;
   logic [DATA_W:0]   sum;
   logic [ADDR_W-1:0] idx;
   logic [DATA_W-1:0] st_val, ram_q, wb_data;

   assign sum = {1'b0, bus.base} + {1'b0, bus.offset};
   assign idx = sum[ADDR_W-1:0];

`ifdef MEM_BOUNDS_CHECK_EN
   assign oob = (sum >= (DATA_W+1)'(DEPTH));
`else
   logic unused_hi;
   assign unused_hi = ^sum[DATA_W:ADDR_W];
   assign oob       = 1'b0;
`endif

   // wb_data is zero outside the valid pulse, so ST_WB forwards 0 then
   assign wb_data = wb_vld ? ram_q : '0;

   always_comb begin
      unique case (bus.st_sel)
         ST_EXE:  st_val = bus.st_exe_val;
         ST_WB:   st_val = wb_data;
         default: st_val = bus.st_reg_val;
      endcase
   end

   always_comb begin
      state_nx  = state;
      cnt_nx    = cnt;
      wb_vld_nx = 1'b0;
      fault_nx  = 1'b0;
      rd_go     = 1'b0;
      wr_go     = 1'b0;
      if (bus.do_branch) begin
         state_nx = IDLE;
         cnt_nx   = '0;
      end else if (!bus.do_halt) begin
         unique case (state)
            IDLE: begin
               rd_go    = bus.is_mem_read  && !oob;
               wr_go    = bus.is_mem_write && !oob;
               fault_nx = (bus.is_mem_read || bus.is_mem_write) && oob;
               if (rd_go) begin
                  if (RD_LAT == 1) begin
                     wb_vld_nx = bus.is_reg_write;
                  end else begin
                     state_nx = WAIT;
                     cnt_nx   = LAT_CNT;
                  end
               end
            end
            WAIT: begin
               if (cnt == ONE) begin
                  state_nx  = IDLE;
                  cnt_nx    = '0;
                  wb_vld_nx = hold_we;
               end else begin
                  cnt_nx = cnt - ONE;
               end
            end
            default: state_nx = IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         wb_vld   <= 1'b0;
         fault_q  <= 1'b0;
         hold_we  <= 1'b0;
         hold_reg <= '0;
      end else begin
         state   <= state_nx;
         cnt     <= cnt_nx;
         wb_vld  <= wb_vld_nx;
         fault_q <= fault_nx;
         if (rd_go) begin
            hold_we  <= bus.is_reg_write;
            hold_reg <= bus.dst_reg;
         end
      end
   end

   dmem_ram #(.DATA_W(DATA_W), .ADDR_W(ADDR_W)) u_ram (
      .clk   (clk),
      .rst   (rst),
      .re    (rd_go),
      .we    (wr_go),
      .idx   (idx),
      .wdata (st_val),
      .rdata (ram_q)
   );

   assign bus.stall       = (state == WAIT);
   assign bus.wb_valid    = wb_vld;
   assign bus.wb_data     = wb_data;
   assign bus.wb_reg_addr = wb_vld ? hold_reg : '0;
   assign bus.fault       = fault_q;

endmodule
